reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 10 +
 rtl/reg_file.sv | 48 ++++
 tb/tb_reg_file.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and data-word type for the register file.
// Default widths here set the reg_file parameter defaults.
package reg_file_pkg;

    localparam int REG_FILE_DATA_W = 8;
    localparam int REG_FILE_ADDR_W = 2;

    typedef logic [REG_FILE_DATA_W-1:0] word_t;

endpackage

// File: rtl/reg_file.sv
// Two-read / one-write register file with combinational reads and async reset.
// Optional same-cycle write forwarding when REG_FILE_BYPASS_EN is defined.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = REG_FILE_DATA_W,
    parameter int ADDR_W = REG_FILE_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic              write_enable,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    // Address A doubles as the write address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_enable) begin
            regs[address_a] <= write_data;
        end
    end

    always_comb begin
        data_a = regs[address_a];
        data_b = regs[address_b];
`ifdef REG_FILE_BYPASS_EN
        // Forward the in-flight write to any port reading the write address.
        if (write_enable && !reset) begin
            data_a = write_data;
            if (address_b == address_a) begin
                data_b = write_data;
            end
        end
`endif
    end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: expected read values are queued when
// stimulus is driven and compared against both read ports.
module tb_reg_file;
    import reg_file_pkg::*;

    typedef struct {
        string tag;
        word_t a;
        word_t b;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [1:0]  address_a;
    logic [1:0]  address_b;
    logic        write_enable;
    word_t       write_data;
    word_t       data_a;
    word_t       data_b;

    word_t       model [4];
    exp_t        sb [$];
    int          total;
    int          bad;

    reg_file dut (
        .clk          (clk),
        .reset        (reset),
        .address_a    (address_a),
        .address_b    (address_b),
        .write_enable (write_enable),
        .write_data   (write_data),
        .data_a       (data_a),
        .data_b       (data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input word_t got, input word_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h, required 0x%02h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input word_t ea, input word_t eb);
        exp_t e;
        e.tag = tag;
        e.a   = ea;
        e.b   = eb;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 8'h01, 8'h00);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_a"}, data_a, e.a);
            check({e.tag, "_b"}, data_b, e.b);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) model[i] = 8'h00;
    endtask

    // Present a read with write_enable low, expectation from the bench model.
    task automatic do_read(input string tag, input logic [1:0] aa, input logic [1:0] ab);
        write_enable = 1'b0;
        address_a    = aa;
        address_b    = ab;
        push_exp(tag, model[aa], model[ab]);
        #2;
        compare_out();
    endtask

    task automatic do_write(input logic [1:0] addr, input word_t data);
        @(negedge clk);
        address_a    = addr;
        write_data   = data;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        if (!reset) model[addr] = data;
        write_enable = 1'b0;
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        address_a    = 2'd0;
        address_b    = 2'd0;
        write_enable = 1'b0;
        write_data   = 8'h00;
        clear_model();

        // Reset: every address zero on both ports while reset is high.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            do_read($sformatf("rst_addr%0d", i), 2'(i), 2'(3 - i));
        end
        @(negedge clk);
        reset = 1'b0;

        // Write 0xC5 to address 2 and read it back; others stay zero.
        do_write(2'd2, 8'hC5);
        do_read("wr_c5", 2'd0, 2'd2);
        check("wr_c5_const", data_b, 8'hC5);
        for (int i = 0; i < 4; i++) begin
            do_read($sformatf("wr_scan%0d", i), 2'(i), 2'(i));
        end

        // Write gating: 0xFF presented to address 1 with write_enable low.
        do_write(2'd1, 8'h3C);
        @(negedge clk);
        address_a    = 2'd1;
        write_data   = 8'hFF;
        write_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_read("gate", 2'd1, 2'd1);
        check("gate_const", data_a, 8'h3C);

        // Dual read of distinct registers in the same cycle.
        do_write(2'd0, 8'h11);
        do_write(2'd1, 8'h22);
        do_write(2'd2, 8'h33);
        do_write(2'd3, 8'h44);
        do_read("dual", 2'd3, 2'd0);
        check("dual_a_const", data_a, 8'h44);
        check("dual_b_const", data_b, 8'h11);

        // Reset mid-operation: asynchronous clear between edges, writes blocked.
        do_write(2'd0, 8'hAA);
        address_a = 2'd0;
        address_b = 2'd0;
        #1;
        check("pre_rst_aa", data_a, 8'hAA);
        reset = 1'b1;
        clear_model();
        #1;
        check("async_clr", data_a, 8'h00);
        do_write(2'd2, 8'h77);
        do_read("rst_block", 2'd2, 2'd0);
        @(negedge clk);
        reset = 1'b0;
        do_write(2'd1, 8'h66);
        do_read("resume", 2'd1, 2'd2);

        // Same address on write and read port B during the write cycle.
        do_write(2'd3, 8'h12);
        @(negedge clk);
        address_a    = 2'd3;
        address_b    = 2'd3;
        write_data   = 8'h5A;
        write_enable = 1'b1;
        #1;
`ifdef REG_FILE_BYPASS_EN
        push_exp("same_pre", 8'h5A, 8'h5A);
`else
        push_exp("same_pre", model[3], model[3]);
`endif
        compare_out();
        @(posedge clk);
        #1;
        model[3]     = 8'h5A;
        write_enable = 1'b0;
        push_exp("same_post", 8'h5A, 8'h5A);
        #1;
        compare_out();
        do_read("final_scan", 2'd3, 2'd1);

        check("sb_drain", word_t'(sb.size()), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
